// File: rtl/puf_io_pkg.sv
// puf_io_pkg: shared byte width, loader state encodings and word-width check
package puf_io_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, CHK = 2'd2, FULL = 2'd3} state_t;
  function automatic bit width_ok(input int n);
    return (n % BYTE_W) == 0;
  endfunction
endpackage

// File: rtl/byte_xor_accum.sv
// byte_xor_accum: 8-bit running XOR with synchronous clear
module byte_xor_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc ^ din;
endmodule

// File: rtl/challenge_byte_loader.sv
// challenge_byte_loader: assembles an N-bit PUF word from a byte stream, LSB byte first.
// Optional trailing XOR checksum byte enabled by macro CHECKSUM_EN.
module challenge_byte_loader
  import puf_io_pkg::*;
#(
  parameter int N = 264
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  output logic [N-1:0]                  data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [$clog2(N/BYTE_W+1)-1:0] byte_count,
  output logic                          err
);
  localparam int NB = N / BYTE_W;
  localparam int CW = $clog2(NB + 1);
  if (!width_ok(N)) begin : g_bad_width
    $error("challenge_byte_loader: N must be a multiple of 8");
  end
  state_t state;
  logic accept;
  assign accept = byte_valid & byte_ready;
`ifdef CHECKSUM_EN
  logic [7:0] acc;
  byte_xor_accum u_acc (
    .clk(clk), .rst(rst), .clr(start), .en(accept && state == FILL), .din(byte_in), .acc(acc)
  );
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      data_out   <= '0;
      byte_count <= '0;
      data_valid <= 1'b0;
      byte_ready <= 1'b0;
      err        <= 1'b0;
    end else if (start) begin
      state      <= FILL;
      data_out   <= '0;
      byte_count <= '0;
      data_valid <= 1'b0;
      byte_ready <= 1'b1;
      err        <= 1'b0;
    end else if (state == FILL && accept) begin
      data_out   <= {byte_in, data_out[N-1:BYTE_W]};
      byte_count <= (byte_count == CW'(NB)) ? byte_count : byte_count + 1'b1;
      if (byte_count == CW'(NB - 1)) begin
`ifdef CHECKSUM_EN
        state      <= CHK;
`else
        state      <= FULL;
        byte_ready <= 1'b0;
        data_valid <= 1'b1;
`endif
      end
`ifdef CHECKSUM_EN
    end else if (state == CHK && accept) begin
      byte_ready <= 1'b0;
      state      <= (byte_in == acc) ? FULL : IDLE;
      data_valid <= (byte_in == acc);
      err        <= (byte_in != acc);
`endif
    end else if (state == FULL && data_ready) begin
      state      <= IDLE;
      data_valid <= 1'b0;
    end
endmodule
